// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu sharing arbiter: command codes, default widths, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fpu_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_CMD_WIDTH = 4;

    localparam logic [DEF_CMD_WIDTH-1:0] FPU_CMD_ADD  = 4'd0;
    localparam logic [DEF_CMD_WIDTH-1:0] FPU_CMD_SUB  = 4'd1;
    localparam logic [DEF_CMD_WIDTH-1:0] FPU_CMD_MUL  = 4'd2;
    localparam logic [DEF_CMD_WIDTH-1:0] FPU_CMD_DIV  = 4'd3;
    localparam logic [DEF_CMD_WIDTH-1:0] FPU_CMD_SQRT = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant plus binary index, searching upward from ptr with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the grant with its own ready condition.
// Ports: req (pending requests), ptr (highest-priority index), grant (one-hot), grant_idx (binary).
module rr_arbiter
    import fpu_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int IDXW       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDXW-1:0]       ptr,
    output logic [REQUESTERS-1:0] grant,
    output logic [IDXW-1:0]       grant_idx
);

    localparam logic [IDXW:0] NREQ = (IDXW+1)'(REQUESTERS);

    logic [IDXW:0]   sum;
    logic [IDXW-1:0] cand;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int off = 0; off < REQUESTERS; off++) begin
            // candidate = (ptr + off) mod REQUESTERS, one extra bit avoids overflow
            sum = {1'b0, ptr} + (IDXW+1)'(off);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = sum[IDXW-1:0];
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fpu between REQUESTERS clients (round-robin), with a watchdog error response.
// Latency: grant t -> LOAD t+1 -> RUN t+2; fpu_done at d -> resp_valid at d+1.
// Backpressure: req_ready only in IDLE; one operation in flight, no response backpressure.
// Ports: req_* client request side, resp_* one-hot response pulse, busy status, fpu_* datapath side.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [REQUESTERS-1:0]            req_valid,
    output logic [REQUESTERS-1:0]            req_ready,
    input  logic [REQUESTERS*CMD_WIDTH-1:0]  req_command,
    input  logic [REQUESTERS*WIDTH-1:0]      req_first,
    input  logic [REQUESTERS*WIDTH-1:0]      req_second,
    output logic [REQUESTERS-1:0]            resp_valid,
    output logic [WIDTH-1:0]                 resp_result,
    output logic                             resp_error,
    output logic                             busy,
    output logic [CMD_WIDTH-1:0]             fpu_command,
    output logic [WIDTH-1:0]                 fpu_first,
    output logic [WIDTH-1:0]                 fpu_second,
    output logic                             fpu_reset,
    input  logic                             fpu_done,
    input  logic [WIDTH-1:0]                 fpu_result
);

    localparam int              IDXW     = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int              CNTW     = $clog2(TIMEOUT + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(REQUESTERS - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         ptr_q, ptr_d;
    logic [IDXW-1:0]         owner_q, owner_d;
    logic [CMD_WIDTH-1:0]    cmd_q, cmd_d;
    logic [WIDTH-1:0]        first_q, first_d;
    logic [WIDTH-1:0]        second_q, second_d;
    logic [CNTW-1:0]         wdog_q, wdog_d;
    logic [REQUESTERS-1:0]   resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]        resp_result_q, resp_result_d;
    logic                    resp_error_q, resp_error_d;
    logic                    busy_q, busy_d;
    logic                    fpu_reset_q, fpu_reset_d;

    logic [REQUESTERS-1:0]   grant;
    logic [IDXW-1:0]         grant_idx;
    logic                    handshake;
    logic [CMD_WIDTH-1:0]    sel_cmd;
    logic [WIDTH-1:0]        sel_first;
    logic [WIDTH-1:0]        sel_second;

    rr_arbiter #(
        .REQUESTERS (REQUESTERS),
        .IDXW       (IDXW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    // AND-OR payload mux keyed by the one-hot grant
    always_comb begin
        sel_cmd    = '0;
        sel_first  = '0;
        sel_second = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant[i]) begin
                sel_cmd    = req_command[i*CMD_WIDTH +: CMD_WIDTH];
                sel_first  = req_first[i*WIDTH +: WIDTH];
                sel_second = req_second[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        cmd_d         = cmd_q;
        first_d       = first_q;
        second_d      = second_q;
        wdog_d        = wdog_q;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        resp_error_d  = resp_error_q;
        busy_d        = busy_q;
        fpu_reset_d   = fpu_reset_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d     = ST_LOAD;
                    owner_d     = grant_idx;
                    cmd_d       = sel_cmd;
                    first_d     = sel_first;
                    second_d    = sel_second;
                    ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    busy_d      = 1'b1;
                    fpu_reset_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // operands are already stable on fpu_*; release fpu reset next cycle
                state_d     = ST_RUN;
                wdog_d      = '0;
                fpu_reset_d = 1'b0;
            end
            ST_RUN: begin
                if (fpu_done) begin
                    state_d               = ST_RESP;
                    resp_valid_d[owner_q] = 1'b1;
                    resp_result_d         = fpu_result;
                    resp_error_d          = 1'b0;
                    fpu_reset_d           = 1'b1;
                end else if (wdog_q == CNT_LAST) begin
                    // this would be the TIMEOUT-th RUN cycle without done
                    state_d               = ST_RESP;
                    resp_valid_d[owner_q] = 1'b1;
                    resp_result_d         = '0;
                    resp_error_d          = 1'b1;
                    fpu_reset_d           = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                fpu_reset_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            cmd_q         <= '0;
            first_q       <= '0;
            second_q      <= '0;
            wdog_q        <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_error_q  <= 1'b0;
            busy_q        <= 1'b0;
            fpu_reset_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            cmd_q         <= cmd_d;
            first_q       <= first_d;
            second_q      <= second_d;
            wdog_q        <= wdog_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_error_q  <= resp_error_d;
            busy_q        <= busy_d;
            fpu_reset_q   <= fpu_reset_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_error  = resp_error_q;
    assign busy        = busy_q;
    assign fpu_command = cmd_q;
    assign fpu_first   = first_q;
    assign fpu_second  = second_q;
    assign fpu_reset   = fpu_reset_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a behavioural fpu stub (hang and forced-done controls).
// Latency: stub raises done on its third RUN cycle unless hung.
// Backpressure: clients hold valid until granted, then drop it.
module tb_fpu_arbiter;
    import fpu_pkg::*;

    localparam int N        = 4;
    localparam int W        = 32;
    localparam int CW       = 4;
    localparam int TO       = 16;
    localparam int STUB_LAT = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*CW-1:0]   req_command;
    logic [N*W-1:0]    req_first;
    logic [N*W-1:0]    req_second;
    logic [N-1:0]      resp_valid;
    logic [W-1:0]      resp_result;
    logic              resp_error;
    logic              busy;
    logic [CW-1:0]     fpu_command;
    logic [W-1:0]      fpu_first;
    logic [W-1:0]      fpu_second;
    logic              fpu_reset;
    logic              fpu_done;
    logic [W-1:0]      fpu_result;

    fpu_arbiter #(
        .REQUESTERS (N),
        .WIDTH      (W),
        .CMD_WIDTH  (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_command (req_command),
        .req_first   (req_first),
        .req_second  (req_second),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_error  (resp_error),
        .busy        (busy),
        .fpu_command (fpu_command),
        .fpu_first   (fpu_first),
        .fpu_second  (fpu_second),
        .fpu_reset   (fpu_reset),
        .fpu_done    (fpu_done),
        .fpu_result  (fpu_result)
    );

    always #5 clock = ~clock;

    // fpu stub: ADD of equal normal operands doubles (exponent + 1), otherwise XOR
    logic       stub_hang  = 1'b0;
    logic       stub_force = 1'b0;
    logic [7:0] run_cnt    = 8'd0;
    int         cyc        = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (fpu_reset) run_cnt <= 8'd0;
        else           run_cnt <= run_cnt + 8'd1;
    end

    assign fpu_done   = stub_force | (!fpu_reset && !stub_hang && run_cnt == 8'(STUB_LAT));
    assign fpu_result = (fpu_command == FPU_CMD_ADD && fpu_first == fpu_second)
                        ? fpu_first + 32'h0080_0000 : fpu_first ^ fpu_second;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    task automatic set_req(input int p, input logic [CW-1:0] cmd,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_command[p*CW +: CW] = cmd;
        req_first[p*W +: W]     = a;
        req_second[p*W +: W]    = b;
    endtask

    // both waits advance at least one negedge, then stop on the event or after 200 cycles
    task automatic wait_resp(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (resp_valid == '0 && cycles < 200);
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (req_ready == '0 && cycles < 200);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int c;
        int last_g;
        int seen;
        reset       = 1'b1;
        req_valid   = '0;
        req_command = '0;
        req_first   = '0;
        req_second  = '0;
        last_g      = 0;

        // reset state
        repeat (3) @(posedge clock);
        samp();
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_resp_valid", resp_valid, 4'b0000);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_resp_error", resp_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fpu_command", fpu_command, 4'h0);
        chk("rst_fpu_first", fpu_first, 32'h0);
        chk("rst_fpu_second", fpu_second, 32'h0);
        chk("rst_fpu_reset", fpu_reset, 1'b1);

        // single request on port 2
        step();
        reset = 1'b0;
        set_req(2, FPU_CMD_ADD, 32'hBF3F_FFFF, 32'hBF3F_FFFF);
        req_valid = 4'b0100;
        samp();
        chk("single_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        samp();
        chk("single_load_ready", req_ready, 4'b0000);
        chk("single_load_busy", busy, 1'b1);
        chk("single_load_fpu_reset", fpu_reset, 1'b1);
        chk("single_load_cmd", fpu_command, FPU_CMD_ADD);
        chk("single_load_first", fpu_first, 32'hBF3F_FFFF);
        chk("single_load_second", fpu_second, 32'hBF3F_FFFF);
        samp();
        chk("single_run_fpu_reset", fpu_reset, 1'b0);
        wait_resp(c);
        chk("single_resp_latency", c, 3);
        chk("single_resp_valid", resp_valid, 4'b0100);
        chk("single_resp_result", resp_result, 32'hBFBF_FFFF);
        chk("single_resp_error", resp_error, 1'b0);
        chk("single_resp_fpu_reset", fpu_reset, 1'b1);
        samp();
        chk("single_after_resp_valid", resp_valid, 4'b0000);
        chk("single_after_busy", busy, 1'b0);

        // fairness: pointer back to 0, all four ports valid continuously
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, FPU_CMD_MUL, 32'h3F80_0000 + i, 32'h0000_00F0 + i);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(c);
            chk($sformatf("fair_grant_%0d", k), req_ready, 4'b0001 << (k % 4));
            if (k > 0) chk($sformatf("fair_gap_%0d", k), cyc - last_g, 6);
            last_g = cyc;
            step();
            if (k == 4) req_valid = '0;
        end
        wait_resp(c);
        chk("fair_last_resp_valid", resp_valid, 4'b0001);
        chk("fair_last_resp_result", resp_result, 32'h3F80_00F0);

        // busy blocking: port 1 raises valid while port 0 is in RUN
        step();
        req_valid = 4'b0001;
        samp();
        chk("block_grant0", req_ready, 4'b0001);
        step();
        req_valid = '0;
        samp();
        step();
        req_valid = 4'b0010;
        samp();
        chk("block_run_ready", req_ready, 4'b0000);
        chk("block_run_busy", busy, 1'b1);
        wait_grant(c);
        chk("block_grant1", req_ready, 4'b0010);
        chk("block_grant1_wait", c, 4);
        step();
        req_valid = '0;
        wait_resp(c);
        chk("block_resp_valid", resp_valid, 4'b0010);
        chk("block_resp_result", resp_result, 32'h3F80_00F0);

        // watchdog: stub never finishes
        stub_hang = 1'b1;
        step();
        set_req(3, FPU_CMD_DIV, 32'h4000_0000, 32'h0000_0000);
        req_valid = 4'b1000;
        samp();
        chk("to_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        samp();
        wait_resp(c);
        chk("to_latency_from_load", c, TO + 1);
        chk("to_resp_valid", resp_valid, 4'b1000);
        chk("to_resp_error", resp_error, 1'b1);
        chk("to_resp_result", resp_result, 32'h0);

        // reset asserted on the third RUN cycle
        step();
        req_valid = 4'b0010;
        samp();
        chk("mid_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        samp();
        step();
        samp();
        step();
        samp();
        step();
        reset = 1'b1;
        samp();
        chk("mid_run3_fpu_reset", fpu_reset, 1'b0);
        step();
        reset = 1'b0;
        samp();
        chk("mid_busy", busy, 1'b0);
        chk("mid_fpu_reset", fpu_reset, 1'b1);
        chk("mid_resp_valid", resp_valid, 4'b0000);
        chk("mid_fpu_first", fpu_first, 32'h0);
        stub_hang = 1'b0;
        seen = 0;
        for (int i = 0; i < TO + 8; i++) begin
            samp();
            if (resp_valid != '0) seen++;
        end
        chk("mid_no_resp", seen, 0);

        // stale done in IDLE and LOAD
        step();
        stub_force = 1'b1;
        samp();
        chk("stale_idle_resp", resp_valid, 4'b0000);
        chk("stale_idle_busy", busy, 1'b0);
        step();
        set_req(0, FPU_CMD_SUB, 32'h4049_0FDB, 32'h0000_FFFF);
        req_valid = 4'b0001;
        samp();
        chk("stale_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        samp();
        chk("stale_load_busy", busy, 1'b1);
        chk("stale_load_fpu_reset", fpu_reset, 1'b1);
        chk("stale_load_resp", resp_valid, 4'b0000);
        step();
        stub_force = 1'b0;
        samp();
        chk("stale_run_fpu_reset", fpu_reset, 1'b0);
        chk("stale_run_resp", resp_valid, 4'b0000);
        wait_resp(c);
        chk("stale_resp_latency", c, 3);
        chk("stale_resp_valid", resp_valid, 4'b0001);
        chk("stale_resp_result", resp_result, 32'h4049_F024);
        chk("stale_resp_error", resp_error, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
